// File: rtl/alu_pkg.sv
// Shared definitions for the shared-adder arbiter slice.
//   ALU_W        operand width of the shared carry-lookahead adder
//   ALU_NREQ     default number of requesters
//   ALU_IDW_MAX  tag width that covers the largest supported NREQ (8)
//   alu_rsp_t    response bundle {id, sum, cout} held in the output register
//   rr_next()    wrap-around increment used to advance the round-robin pointer
package alu_pkg;

  localparam int ALU_W       = 32;
  localparam int ALU_NREQ    = 3;
  localparam int ALU_IDW_MAX = 3;

  typedef struct packed {
    logic [ALU_IDW_MAX-1:0] id;
    logic [ALU_W-1:0]       sum;
    logic                   cout;
  } alu_rsp_t;

  // Index after 'idx' in a ring of 'nreq' slots.
  function automatic logic [ALU_IDW_MAX-1:0] rr_next(input logic [ALU_IDW_MAX-1:0] idx,
                                                     input int nreq);
    logic [ALU_IDW_MAX-1:0] nxt;
    nxt = (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/CLA32.sv
// 32-bit carry-lookahead adder used across the core.
// Eight 4-bit lookahead groups; group generate/propagate terms produce the
// group carries, and each group expands its internal carries from its own
// carry-in.
// Ports:
//   a, b   32-bit operands
//   cin    carry-in
//   s      32-bit sum
//   cout   carry-out (bit 32 of a+b+cin)
module CLA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [32:0] c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    c[0] = cin;

    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end

    // Group carries ripple through the group-level terms only.
    for (int j = 0; j < 8; j++) begin
      c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
    end

    // In-group carries come straight from the group carry-in.
    for (int j = 0; j < 8; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end

    s    = p ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   req         per-requester request vector
//   advance     pulse on a completed handshake; moves the pointer past the winner
//   grant       one-hot winner (zero when no request)
//   idx         encoded winner index
//   any         at least one request is present
module rr_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = ALU_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] rr_ptr;

  // Scan from rr_ptr upward, wrapping; the first requester found wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop; a path that left one
    // unassigned would make synthesis infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = IDW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= IDW'(rr_next(ALU_IDW_MAX'(idx), NREQ));
    end
  end

endmodule

// File: rtl/alu_adder_arbiter.sv
// Shares one CLA32 among NREQ requesters (ALU add, branch target, PC+4, ...).
// A round-robin arbiter picks one valid request per cycle; its operands feed
// the adder and the sum is captured in a one-entry valid/ready output register
// tagged with the requester index. A drain and a new grant in the same cycle
// replace the held result back-to-back, giving one result per cycle.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid / req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b           packed operands, requester i at [i*W +: W]
//   req_cin                per-requester carry-in
//   req_sub                per-requester subtract select (ADDER_ARB_SUB_EN only)
//   rsp_valid / rsp_ready  result handshake
//   rsp_id, rsp_sum, rsp_cout  registered result
// Configuration: define ADDER_ARB_SUB_EN to add req_sub; a set bit makes the
// adder compute a + ~b + 1 (cout=1 means no borrow) and ignores req_cin.
module alu_adder_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = ALU_NREQ,
  parameter int W    = ALU_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  idx;
  logic            any;
  logic            can_accept;
  logic            hs;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_cin;
  logic [W-1:0]    add_s;
  logic            add_cout;
  alu_rsp_t        rsp_q;

  // The output slot is free if empty or being drained this cycle; no grant is
  // issued while reset is asserted.
  assign can_accept = !rsp_valid || rsp_ready;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign hs         = |(req_valid & req_ready);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (hs),
    .grant   (grant),
    .idx     (idx),
    .any     (any)
  );

  // Operand mux driven by the arbiter winner.
  always_comb begin
    add_a   = req_a[int'(idx)*W +: W];
    add_b   = req_b[int'(idx)*W +: W];
    add_cin = req_cin[idx];
`ifdef ADDER_ARB_SUB_EN
    if (req_sub[idx]) begin
      add_b   = ~add_b;
      add_cin = 1'b1;
    end
`endif
  end

  CLA32 u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Payload only loads on a handshake, so it holds across idle cycles even
  // after rsp_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (hs) begin
      rsp_valid  <= 1'b1;
      rsp_q.id   <= ALU_IDW_MAX'(idx);
      rsp_q.sum  <= add_s;
      rsp_q.cout <= add_cout;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_id   = rsp_q.id[IDW-1:0];
  assign rsp_sum  = rsp_q.sum;
  assign rsp_cout = rsp_q.cout;

  // Tag bits above IDW are always zero for this NREQ and are dropped on purpose.
  if (IDW < ALU_IDW_MAX) begin : g_id_pad
    logic [ALU_IDW_MAX-IDW-1:0] id_pad_unused;
    assign id_pad_unused = rsp_q.id[ALU_IDW_MAX-1:IDW];
  end

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Self-checking bench for alu_adder_arbiter. Expected results are pushed to a
// scoreboard queue when a grant is predicted and compared while the result is
// held. A round-robin reference pointer predicts req_ready each cycle.
module tb_alu_adder_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
`ifdef ADDER_ARB_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  alu_adder_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;
  int   exp_ptr = 0;
  bit   keep_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    int cand;
    for (int k = 0; k < NREQ; k++) begin
      cand = (exp_ptr + k) % NREQ;
      if (req_valid[cand]) return cand;
    end
    return -1;
  endfunction

  function automatic exp_t model(input int w);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   s;
    exp_t         e;
    a   = req_a[w*W +: W];
    b   = req_b[w*W +: W];
    cin = req_cin[w];
`ifdef ADDER_ARB_SUB_EN
    if (req_sub[w]) begin
      b   = ~b;
      cin = 1'b1;
    end
`endif
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = IDW'(w);
    e.sum  = s[W-1:0];
    e.cout = s[W];
    return e;
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
  endtask

  // One clock cycle: compare outputs and req_ready before the edge, then
  // update the reference state after it.
  task automatic step();
    int              w;
    logic [NREQ-1:0] exp_rdy;
    bit              can_acc;
    bit              hs;
    bit              drain;
    exp_t            e;
    exp_t            e_new;
    #1;
    check("rsp_valid", rsp_valid, sb.size() != 0);
    e = (sb.size() != 0) ? sb[0] : last;
    check("rsp_id", rsp_id, e.id);
    check("rsp_sum", rsp_sum, e.sum);
    check("rsp_cout", rsp_cout, e.cout);

    w       = pick();
    can_acc = (sb.size() == 0) || rsp_ready;
    exp_rdy = '0;
    if (rst_n && can_acc && w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    hs    = (exp_rdy != 0);
    drain = (sb.size() != 0) && rsp_ready;
    e_new = '{id: '0, sum: '0, cout: 1'b0};
    if (hs) e_new = model(w);

    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      last    = '{id: '0, sum: '0, cout: 1'b0};
      exp_ptr = 0;
    end else begin
      if (drain) last = sb.pop_front();
      if (hs) begin
        sb.push_back(e_new);
        exp_ptr = (w + 1) % NREQ;
        if (!keep_valid) req_valid[w] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    last      = '{id: '0, sum: '0, cout: 1'b0};
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub   = '0;
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 32'(i + 1), 32'(10 * i), 1'b0);

    // Reset with every requester valid: nothing is granted, outputs cleared.
    @(posedge clk);
    #1;
    step();
    step();

    // First grant after release goes to requester 0.
    rst_n = 1'b1;
    step();
    check("first_grant_id", rsp_id, 0);
    req_valid = '0;
    step();
    step();

    // Single add on requester 0.
    set_lane(0, 32'h0000_0005, 32'h0000_0005, 1'b1);
    req_valid = 3'b001;
    step();
    check("add_sum", rsp_sum, 32'h0000_000B);
    check("add_cout", rsp_cout, 0);
    check("add_id", rsp_id, 0);
    step();

    // Carry-out on requester 2.
    set_lane(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 3'b100;
    step();
    check("carry_sum", rsp_sum, 32'h0000_0000);
    check("carry_cout", rsp_cout, 1);
    check("carry_id", rsp_id, 2);
    step();

    // Saturation: grants rotate 0,1,2,0,1,2 with one result per cycle.
    keep_valid = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 32'h1000_0000 * (i + 1), 32'h0000_0100 + i, 1'(i));
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, k % NREQ);
    end

    // Backpressure: held result, no grants; release grants the same cycle.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rsp_ready = 1'b1;
    step();
    check("bp_valid", rsp_valid, 1);
    check("bp_id", rsp_id, 0);
    keep_valid = 1'b0;
    req_valid  = '0;
    step();
    step();

    // Reset while a result is pending discards it.
    set_lane(1, 32'h0000_1234, 32'h0000_4321, 1'b1);
    req_valid = 3'b010;
    rsp_ready = 1'b0;
    step();
    rst_n     = 1'b0;
    req_valid = '1;
    step();
    step();
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_sum", rsp_sum, 0);
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();

    // Random traffic; requesters hold until granted.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          set_lane(i, ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom,
                   $urandom, 1'($urandom_range(1, 0)));
`ifdef ADDER_ARB_SUB_EN
          req_sub[i] = 1'($urandom_range(1, 0));
`endif
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();

`ifdef ADDER_ARB_SUB_EN
    // Subtract on requester 1, with and without borrow.
    req_sub = '0;
    req_sub[1] = 1'b1;
    set_lane(1, 32'h0000_0010, 32'h0000_0003, 1'b0);
    req_valid = 3'b010;
    step();
    check("sub_sum", rsp_sum, 32'h0000_000D);
    check("sub_cout", rsp_cout, 1);
    set_lane(1, 32'h0000_0003, 32'h0000_0010, 1'b0);
    req_valid = 3'b010;
    step();
    check("sub_borrow_sum", rsp_sum, 32'hFFFF_FFF3);
    check("sub_borrow_cout", rsp_cout, 0);
    req_sub = '0;
    step();
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
